pe_result_packer: RTL and testbench

PE_RESULT_PACKER -- requirements
Module: pe_result_packer

---
 rtl/pe_result_packer_pkg.sv | 13 +
 rtl/pe_result_packer.sv | 115 +++++++++++
 tb/tb_pe_result_packer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_result_packer_pkg.sv
// pe_result_packer_pkg: shared FSM state type and word-count helper for the PE result packer
package pe_result_packer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    function automatic int word_num(input int mac_num, input int pack_num);
        return (mac_num + pack_num - 1) / pack_num;
    endfunction

endpackage

// File: rtl/pe_result_packer.sv
// pe_result_packer: snapshots PE lane results and streams them as packed, strobed words
module pe_result_packer
    import pe_result_packer_pkg::*;
#(
    parameter int MAC_NUM  = 10,
    parameter int BW_ACT   = 8,
    parameter int PACK_NUM = 4,
    parameter int ADDR_W   = 16
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                cap_start,
    input  logic [ADDR_W-1:0]                   base_addr,
    input  logic [MAC_NUM-1:0][BW_ACT-1:0]      PE_result_in,
    output logic                                wr_valid,
    input  logic                                wr_ready,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic [PACK_NUM*BW_ACT-1:0]          wr_data,
    output logic [PACK_NUM-1:0]                 wr_strb,
    output logic                                busy,
    output logic                                done,
    output logic                                overrun,
    input  logic                                clr_overrun
);

    localparam int WORD_NUM = word_num(MAC_NUM, PACK_NUM);
    localparam int LANE_NUM = WORD_NUM * PACK_NUM;
    localparam int KW       = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;

    state_t                          state;
    logic [KW-1:0]                   k;
    logic [LANE_NUM-1:0][BW_ACT-1:0] snap;
    logic [LANE_NUM-1:0][BW_ACT-1:0] in_pad;
    logic                            last;
    logic                            hs;

    // Lanes past MAC_NUM exist only so every word can be sliced uniformly; they stay zero.
    function automatic logic [PACK_NUM*BW_ACT-1:0] pack_word(
        input logic [LANE_NUM-1:0][BW_ACT-1:0] lanes,
        input int                              idx
    );
        logic [PACK_NUM*BW_ACT-1:0] w;
        w = '0;
        for (int p = 0; p < PACK_NUM; p++) w[p*BW_ACT +: BW_ACT] = lanes[idx*PACK_NUM+p];
        return w;
    endfunction

    function automatic logic [PACK_NUM-1:0] strb_word(input int idx);
        logic [PACK_NUM-1:0] s;
        for (int p = 0; p < PACK_NUM; p++) s[p] = (idx * PACK_NUM + p) < MAC_NUM;
        return s;
    endfunction

    // Zero-padded view of the incoming lanes so the capture word can be sliced like the snapshot.
    always_comb begin
        in_pad = '0;
        for (int i = 0; i < MAC_NUM; i++) in_pad[i] = PE_result_in[i];
    end

    assign last = (k == KW'(WORD_NUM - 1));
    assign hs   = wr_valid && wr_ready;

    // Capture/write FSM; outputs are registered and loaded one word ahead of each handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            k        <= '0;
            snap     <= '0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_strb  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (cap_start) begin
                    state    <= WRITE;
                    k        <= '0;
                    snap     <= in_pad;
                    wr_valid <= 1'b1;
                    busy     <= 1'b1;
                    wr_addr  <= base_addr;
                    wr_data  <= pack_word(in_pad, 0);
                    wr_strb  <= strb_word(0);
                end
            end else if (hs) begin
                if (last) begin
                    state    <= IDLE;
                    k        <= '0;
                    wr_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    wr_addr  <= '0;
                    wr_data  <= '0;
                    wr_strb  <= '0;
                end else begin
                    k       <= k + KW'(1);
                    wr_addr <= wr_addr + ADDR_W'(1);
                    wr_data <= pack_word(snap, int'(k) + 1);
                    wr_strb <= strb_word(int'(k) + 1);
                end
            end
        end
    end

    // Sticky flag for captures dropped while a write burst is in flight; a new drop beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overrun <= 1'b0;
        else if (cap_start && state == WRITE) overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_pe_result_packer.sv
// tb_pe_result_packer: directed and random stimulus checked against a queue-based write model
module tb_pe_result_packer;

    localparam int MAC_NUM  = 10;
    localparam int BW_ACT   = 8;
    localparam int PACK_NUM = 4;
    localparam int ADDR_W   = 16;
    localparam int WORD_NUM = 3;

    logic                           clk = 1'b0;
    logic                           reset_n = 1'b0;
    logic                           cap_start = 1'b0;
    logic                           wr_ready = 1'b0;
    logic                           clr_overrun = 1'b0;
    logic [ADDR_W-1:0]              base_addr = '0;
    logic [MAC_NUM-1:0][BW_ACT-1:0] pe_in = '0;
    logic                           wr_valid, busy, done, overrun;
    logic [ADDR_W-1:0]              wr_addr;
    logic [PACK_NUM*BW_ACT-1:0]     wr_data;
    logic [PACK_NUM-1:0]            wr_strb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_result_packer #(
        .MAC_NUM(MAC_NUM), .BW_ACT(BW_ACT), .PACK_NUM(PACK_NUM), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cap_start(cap_start), .base_addr(base_addr),
        .PE_result_in(pe_in), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_strb(wr_strb), .busy(busy), .done(done), .overrun(overrun),
        .clr_overrun(clr_overrun)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: a capture becomes a list of pending writes; a handshake pops the front.
    typedef struct {
        logic [ADDR_W-1:0]          addr;
        logic [PACK_NUM*BW_ACT-1:0] data;
        logic [PACK_NUM-1:0]        strb;
    } wr_t;

    wr_t q[$];
    wr_t e;
    bit  m_done = 0;
    bit  m_over = 0;
    bit  m_busy;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_done = 0;
            m_over = 0;
        end else begin
            m_busy = q.size() != 0;
            m_done = 0;
            if (m_busy && cap_start) m_over = 1;
            else if (clr_overrun) m_over = 0;
            if (m_busy && wr_ready) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1;
            end else if (!m_busy && cap_start) begin
                for (int w = 0; w < WORD_NUM; w++) begin
                    e.addr = ADDR_W'(base_addr + w);
                    e.data = '0;
                    e.strb = '0;
                    for (int p = 0; p < PACK_NUM; p++)
                        if (w * PACK_NUM + p < MAC_NUM) begin
                            e.data[p*BW_ACT +: BW_ACT] = pe_in[w*PACK_NUM+p];
                            e.strb[p] = 1'b1;
                        end
                    q.push_back(e);
                end
            end
        end
    end

    // Every cycle out of reset, the DUT outputs must match the model's view.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("valid", wr_valid, q.size() != 0);
            chk("busy", busy, q.size() != 0);
            chk("done", done, m_done);
            chk("overrun", overrun, m_over);
            if (q.size() != 0) begin
                chk("addr", wr_addr, q[0].addr);
                chk("data", wr_data, q[0].data);
                chk("strb", wr_strb, q[0].strb);
            end
        end
    end

    task automatic capture(input logic [ADDR_W-1:0] a, input logic [MAC_NUM-1:0][BW_ACT-1:0] lanes);
        @(negedge clk);
        base_addr = a;
        pe_in     = lanes;
        cap_start = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
        for (int i = 0; i < MAC_NUM; i++) pe_in[i] = 8'($urandom());
        base_addr = 16'($urandom());
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", busy, 1'b0);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, wr_valid, 0);
        chk({name, "_addr"}, wr_addr, 0);
        chk({name, "_data"}, wr_data, 0);
        chk({name, "_strb"}, wr_strb, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_over"}, overrun, 0);
    endtask

    logic [MAC_NUM-1:0][BW_ACT-1:0] lanes;
    int i;

    initial begin
        // Reset state
        #12;
        chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Basic capture at full rate
        wr_ready = 1'b1;
        for (int j = 0; j < MAC_NUM; j++) lanes[j] = 8'(j + 1);
        capture(16'h0100, lanes);
        chk("b_addr0", wr_addr, 16'h0100);
        chk("b_data0", wr_data, 32'h04030201);
        chk("b_strb0", wr_strb, 4'b1111);
        @(negedge clk);
        chk("b_addr1", wr_addr, 16'h0101);
        chk("b_data1", wr_data, 32'h08070605);
        @(negedge clk);
        chk("b_addr2", wr_addr, 16'h0102);
        chk("b_data2", wr_data, 32'h00000A09);
        chk("b_strb2", wr_strb, 4'b0011);
        @(negedge clk);
        chk("b_done", done, 1'b1);
        chk("b_valid_off", wr_valid, 1'b0);
        @(negedge clk);
        chk("b_done_pulse", done, 1'b0);

        // Negative lanes pack bit-exact without sign extension
        for (int j = 0; j < MAC_NUM; j++) lanes[j] = 8'(j);
        lanes[0] = 8'h80;
        lanes[1] = 8'h7F;
        lanes[2] = 8'hFF;
        lanes[3] = 8'h05;
        capture(16'h0010, lanes);
        chk("neg_data0", wr_data, 32'h05FF7F80);
        wait_idle();

        // Back-pressure: ready high one cycle in four
        wr_ready = 1'b0;
        for (int j = 0; j < MAC_NUM; j++) lanes[j] = 8'($urandom());
        capture(16'h0A00, lanes);
        i = 0;
        while (!done && i < 40) begin
            wr_ready = (i % 4 == 3);
            @(negedge clk);
            i++;
        end
        chk("bp_cycles", 64'(i), 12);
        wr_ready = 1'b1;
        @(negedge clk);

        // Address wrap
        capture(16'hFFFE, lanes);
        chk("wrap0", wr_addr, 16'hFFFE);
        @(negedge clk);
        chk("wrap1", wr_addr, 16'hFFFF);
        @(negedge clk);
        chk("wrap2", wr_addr, 16'h0000);
        wait_idle();

        // Overrun: drop while busy, accept in the done cycle, set beats clear
        wr_ready = 1'b0;
        capture(16'h0200, lanes);
        base_addr = 16'h0300;
        cap_start = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_addr_kept", wr_addr, 16'h0200);
        wr_ready = 1'b1;
        i = 0;
        while (!done && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("ovr_done_seen", done, 1'b1);
        base_addr = 16'h0400;
        cap_start = 1'b1;
        wr_ready = 1'b0;
        @(negedge clk);
        cap_start = 1'b0;
        chk("ovr_accept_valid", wr_valid, 1'b1);
        chk("ovr_accept_addr", wr_addr, 16'h0400);
        cap_start = 1'b1;
        clr_overrun = 1'b1;
        @(negedge clk);
        cap_start = 1'b0;
        chk("ovr_set_wins", overrun, 1'b1);
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("ovr_cleared", overrun, 1'b0);
        wr_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a burst, after word 0
        capture(16'h0500, lanes);
        @(negedge clk);
        chk("rst_mid_word1", wr_addr, 16'h0501);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_after_valid", wr_valid, 1'b0);
            chk("rst_after_done", done, 1'b0);
        end

        // Random traffic
        repeat (2000) begin
            @(negedge clk);
            cap_start   = ($urandom_range(0, 5) == 0);
            base_addr   = 16'($urandom());
            wr_ready    = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < MAC_NUM; j++) pe_in[j] = 8'($urandom());
        end
        cap_start = 1'b0;
        wr_ready  = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
